// File: rtl/cpu_pkg.sv
// Shared definitions for the bus processor sequencer: opcodes, step encoding
// and the MSB-first register select ordering used on the bus enables.
package cpu_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    // R0 sits in the MSB of every 8-bit register select vector.
    localparam logic [7:0] BUS_SEL_R0 = 8'b1000_0000;

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return BUS_SEL_R0 >> idx;
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 decoder with enable; output is MSB-first one-hot (index 0 -> bit 7).
module dec3to8
    import cpu_pkg::*;
(
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot_o
);

    assign onehot_o = en ? onehot(idx) : 8'b0;

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: latches an instruction in T0, then steps T1..T3 and
// decodes bus-source, register-load and ALU controls from the registered step and IR.
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [7:0]        Rout,
    output logic [7:0]        Rin,
    output logic              Gout,
    output logic              DINout,
    output logic              Ain,
    output logic              Gin,
    output logic              AddSub,
    output logic              Done
);

    step_e             step_q, step_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [2:0] x_idx;
    logic [2:0] y_idx;
    logic [2:0] rout_idx;
    logic       rout_en;
    logic       rin_en;
    logic       ir_reserved_unused;

    assign opcode = ir_q[8:6];
    assign x_idx  = ir_q[5:3];
    assign y_idx  = ir_q[2:0];

    // The upper IR bits are reserved and never decoded.
    assign ir_reserved_unused = ^ir_q[DATA_W-1:9];

    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        unique case (step_q)
            T0: begin
                if (Run) begin
                    ir_d   = DIN;
                    step_d = T1;
                end
            end
            T1:      step_d = (opcode == OP_ADD || opcode == OP_SUB) ? T2 : T0;
            T2:      step_d = T3;
            default: step_d = T0;
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // pre-edge values regardless of block evaluation order.
        if (Reset) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves one unassigned and infers a latch.
        rout_en  = 1'b0;
        rout_idx = x_idx;
        rin_en   = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        unique case (step_q)
            T0: ;
            T1: begin
                case (opcode)
                    OP_MV: begin
                        rout_en  = 1'b1;
                        rout_idx = y_idx;
                        rin_en   = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        rin_en = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en = 1'b1;
                        Ain     = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                rout_en  = 1'b1;
                rout_idx = y_idx;
                Gin      = 1'b1;
                AddSub   = (opcode == OP_SUB);
            end
            default: begin
                Gout   = 1'b1;
                rin_en = 1'b1;
                Done   = 1'b1;
            end
        endcase
    end

    // Rin always targets X; Rout selects X or Y as chosen by the decode above.
    dec3to8 u_rin_dec (
        .idx      (x_idx),
        .en       (rin_en),
        .onehot_o (Rin)
    );

    dec3to8 u_rout_dec (
        .idx      (rout_idx),
        .en       (rout_en),
        .onehot_o (Rout)
    );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected-output queue
// model, per-cycle compare, directed literal checks and randomized traffic.
module tb_control_unit;

    localparam int DATA_W = 16;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic [7:0]        Rout;
    logic [7:0]        Rin;
    logic              Gout;
    logic              DINout;
    logic              Ain;
    logic              Gin;
    logic              AddSub;
    logic              Done;

    always #5 Clock = ~Clock;

    control_unit #(.DATA_W(DATA_W)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .DIN    (DIN),
        .Rout   (Rout),
        .Rin    (Rin),
        .Gout   (Gout),
        .DINout (DINout),
        .Ain    (Ain),
        .Gin    (Gin),
        .AddSub (AddSub),
        .Done   (Done)
    );

    typedef struct packed {
        logic [7:0] rout;
        logic [7:0] rin;
        logic       gout;
        logic       dinout;
        logic       ain;
        logic       gin;
        logic       addsub;
        logic       done;
    } outs_t;

    int    n_cmp = 0;
    int    n_err = 0;
    bit    model_valid = 1'b0;
    outs_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] sel(input logic [2:0] i);
        logic [7:0] r0 = 8'h80;
        return r0 >> i;
    endfunction

    function automatic outs_t mk(input logic [7:0] rout, input logic [7:0] rin,
                                 input logic gout, input logic dinout, input logic ain,
                                 input logic gin, input logic addsub, input logic done);
        outs_t o;
        o = {rout, rin, gout, dinout, ain, gin, addsub, done};
        return o;
    endfunction

    function automatic outs_t cur();
        outs_t o;
        o = {Rout, Rin, Gout, DINout, Ain, Gin, AddSub, Done};
        return o;
    endfunction

    // Expand one instruction word into the list of output vectors of its steps.
    task automatic push_instr(input logic [DATA_W-1:0] w);
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        op = w[8:6];
        x  = w[5:3];
        y  = w[2:0];
        case (op)
            3'd0: exp_q.push_back(mk(sel(y), sel(x), 0, 0, 0, 0, 0, 1));
            3'd1: exp_q.push_back(mk(8'h00, sel(x), 0, 1, 0, 0, 0, 1));
            3'd2, 3'd3: begin
                exp_q.push_back(mk(sel(x), 8'h00, 0, 0, 1, 0, 0, 0));
                exp_q.push_back(mk(sel(y), 8'h00, 0, 0, 0, 1, (op == 3'd3), 0));
                exp_q.push_back(mk(8'h00, sel(x), 1, 0, 0, 0, 0, 1));
            end
            default: exp_q.push_back(mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
        endcase
    endtask

    // Reference model: an empty queue means the sequencer is idle in T0.
    always @(posedge Clock) begin
        if (Reset) begin
            exp_q.delete();
            model_valid = 1'b1;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (Run) begin
            push_instr(DIN);
        end
    end

    always @(negedge Clock) begin
        outs_t req;
        if (model_valid) begin
            req = (exp_q.size() != 0) ? exp_q[0] : '0;
            check("cycle_outputs", 32'(cur()), 32'(req));
            check("bus_exclusive", 32'(($countones(Rout) + int'(Gout) + int'(DINout)) <= 1), 32'd1);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = '0;

        // Reset then idle
        tick();
        tick();
        check("reset_outputs", 32'(cur()), 32'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_done", 32'(Done), 32'd0);
        end

        // mvi R3 with immediate presented in T1
        Run = 1'b1; DIN = 16'h0058;
        tick();
        Run = 1'b0; DIN = 16'h00A5;
        check("mvi_t1", 32'(cur()), 32'(mk(8'h00, 8'b0001_0000, 0, 1, 0, 0, 0, 1)));
        tick();
        check("mvi_after", 32'(cur()), 32'd0);

        // mv R1,R6
        Run = 1'b1; DIN = 16'h000E;
        tick();
        Run = 1'b0;
        check("mv_t1", 32'(cur()), 32'(mk(8'b0000_0010, 8'b0100_0000, 0, 0, 0, 0, 0, 1)));
        tick();

        // sub R0,R7
        Run = 1'b1; DIN = 16'h00C7;
        tick();
        Run = 1'b0;
        check("sub_t1", 32'(cur()), 32'(mk(8'b1000_0000, 8'h00, 0, 0, 1, 0, 0, 0)));
        tick();
        check("sub_t2", 32'(cur()), 32'(mk(8'b0000_0001, 8'h00, 0, 0, 0, 1, 1, 0)));
        tick();
        check("sub_t3", 32'(cur()), 32'(mk(8'h00, 8'b1000_0000, 1, 0, 0, 0, 0, 1)));
        tick();

        // add R0,R7 with a Run pulse in T1 that must be ignored
        Run = 1'b1; DIN = 16'h0087;
        tick();
        DIN = 16'h000E;
        check("add_t1", 32'(cur()), 32'(mk(8'b1000_0000, 8'h00, 0, 0, 1, 0, 0, 0)));
        tick();
        Run = 1'b0;
        check("add_t2", 32'(cur()), 32'(mk(8'b0000_0001, 8'h00, 0, 0, 0, 1, 0, 0)));
        tick();
        check("add_t3", 32'(cur()), 32'(mk(8'h00, 8'b1000_0000, 1, 0, 0, 0, 0, 1)));
        tick();
        check("add_then_idle", 32'(cur()), 32'd0);
        tick();
        check("run_pulse_not_queued", 32'(cur()), 32'd0);

        // Back-to-back add then mv with Run held high
        Run = 1'b1; DIN = 16'h0087;
        tick();
        DIN = 16'h000E;
        tick();
        tick();
        check("b2b_add_done", 32'(Done), 32'd1);
        tick();
        check("b2b_t0_gap", 32'(cur()), 32'd0);
        tick();
        Run = 1'b0;
        check("b2b_mv_t1", 32'(cur()), 32'(mk(8'b0000_0010, 8'b0100_0000, 0, 0, 0, 0, 0, 1)));
        tick();

        // Reset during T2 of add
        Run = 1'b1; DIN = 16'h0087;
        tick();
        Run = 1'b0;
        tick();
        Reset = 1'b1;
        check("t2_before_reset_edge", 32'(cur()), 32'(mk(8'b0000_0001, 8'h00, 0, 0, 0, 1, 0, 0)));
        tick();
        check("after_reset_mid", 32'(cur()), 32'd0);
        Reset = 1'b0;
        tick();
        check("no_done_after_abort", 32'(Done), 32'd0);

        // NOP with reserved bits set
        Run = 1'b1; DIN = 16'hFFC0;
        tick();
        Run = 1'b0;
        check("nop_t1", 32'(cur()), 32'(mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 1)));
        tick();
        check("nop_after", 32'(cur()), 32'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 99) < 2);
            Run   = ($urandom_range(0, 9) < 7);
            DIN   = DATA_W'($urandom);
            tick();
        end
        Reset = 1'b1;
        Run   = 1'b0;
        tick();
        Reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 16-bit bus processor. It latches an instruction word from `DIN`, steps through time-steps T0–T3, and drives the bus-select enables consumed directly by `mux`: `Rout`, `Gout` and `DINout`. It also drives the register-load, accumulator and ALU controls. It sits upstream of `mux` and of the R0–R7/A/G registers; at most one bus source is enabled per cycle.

## Interface
Parameters:
- `DATA_W`, 16, width of `DIN` and of the internal instruction register (IR)

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge
- `Reset`  in  1  synchronous, active-high reset
- `Run`  in  1  start request, sampled only in T0
- `DIN`  in  DATA_W  instruction word in T0; immediate operand in T1 of `mvi` (routed to the bus via `DINout`)
- `Rout`  out  8  one-hot bus source select; bit 7 = R0 … bit 0 = R7 (8'b1000_0000 selects R0)
- `Rin`  out  8  one-hot register load enable, same bit ordering as `Rout`
- `Gout`  out  1  drive G onto the bus
- `DINout`  out  1  drive `DIN` onto the bus
- `Ain`  out  1  load A from the bus
- `Gin`  out  1  load G from the ALU
- `AddSub`  out  1  0 = A+bus, 1 = A−bus
- `Done`  out  1  last step of the current instruction

## Operation
- IR fields: `IR[8:6]` opcode, `IR[5:3]` X, `IR[2:0]` Y. `IR[15:9]` is reserved and ignored.
- Opcodes:
  - 000 `mv` Rx←Ry
  - 001 `mvi` Rx←DIN
  - 010 `add` Rx←Rx+Ry
  - 011 `sub` Rx←Rx−Ry
  - 100–111 are NOP
- Step counter states T0, T1, T2, T3, registered.
- T0:
  - if `Run`=1, IR←DIN and go to T1
  - else stay in T0
  - all outputs 0
- T1:
  - `mv`: Rout=onehot(Y), Rin=onehot(X), Done=1, next T0
  - `mvi`: DINout=1, Rin=onehot(X), Done=1, next T0
  - `add`/`sub`: Rout=onehot(X), Ain=1, next T2
  - NOP: Done=1, no enables, next T0
- T2 (`add`/`sub` only): Rout=onehot(Y), Gin=1, AddSub=(opcode==011), next T3.
- T3: Gout=1, Rin=onehot(X), Done=1, next T0.
- onehot(i) = 8'b1000_0000 >> i.
- Invariant: Rout, Gout and DINout are mutually exclusive every cycle, and `Rout` is zero or exactly one-hot.
- Outputs are a pure decode of registered step and IR (Moore); no output depends combinationally on `Run`.
- X==Y is legal, e.g. `add R2,R2` doubles R2.

## Timing
- Latency, counting the T0 load cycle:
  - `mv`/`mvi`/NOP: 2 cycles
  - `add`/`sub`: 4 cycles
- `Done` is high for exactly one cycle, in the final step.
- Back-to-back: with `Run` held high, the next instruction is loaded in the T0 immediately after `Done`, with no idle cycle.
- `Run` pulses outside T0 are ignored and not queued.
- `mvi`: the immediate must be valid on `DIN` in the T1 cycle. The bench changes `DIN` only at clock edges.
- Reset:
  - on the edge with `Reset`=1, step←T0 and IR←0
  - every output is 0 from that edge onward while `Reset` is held
  - `Reset` overrides `Run`
- Reset mid-instruction (T1–T3): the instruction is abandoned and no `Done` is issued.
- The cycle in which `Reset` is high but before its edge still shows the current step's decode.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants `OP_MV`=3'b000, `OP_MVI`=3'b001, `OP_ADD`=3'b010, `OP_SUB`=3'b011
  - step encoding T0–T3 (2-bit)
  - bus-select bit-ordering constant (MSB = R0)
- Sub-module `dec3to8` is instantiated twice, for X→`Rin` and Y/X→`Rout`.
  - Input is a 3-bit index plus enable; output is MSB-first one-hot; enable=0 gives 0.
- Step counter and IR live in `control_unit`.
- Output decode is a single combinational block.

## Test plan
- Reset then idle:
  - stimulus: `Reset`=1 for 2 cycles, `Run`=0 for 5 cycles
  - required: all outputs 0, `Done` never asserts
- `mvi R3`:
  - stimulus: T0 DIN=16'h0058, `Run`=1; T1 DIN=16'h00A5
  - required in T1: DINout=1, Rin=8'b0001_0000, Done=1
  - required next cycle: T0, outputs 0
- `mv R1,R6`:
  - stimulus: DIN=16'h000E
  - required in T1: Rout=8'b0000_0010, Rin=8'b0100_0000, Done=1
- `sub R0,R7`:
  - stimulus: DIN=16'h00C7
  - T1: Rout=8'b1000_0000, Ain=1
  - T2: Rout=8'b0000_0001, Gin=1, AddSub=1
  - T3: Gout=1, Rin=8'b1000_0000, Done=1
  - `add` (16'h0087) is identical except AddSub=0
- Back-to-back with `Run` held high:
  - stimulus: `add` then `mv`
  - required: `mv` IR is loaded in the cycle after `add`'s T3; no bus-source overlap on any cycle
- Reset in T2 of `add`, plus NOP:
  - stimulus: assert `Reset` in T2 of `add`
  - required: next cycle T0, no `Done`, outputs 0
  - stimulus: opcode 3'b111
  - required: Done in T1 with all enables 0
